// File: rtl/ines_pkg.sv
// ines_pkg: shared types and constants for the iNES / NES 2.0 loader.
//   - ines_state_e : loader FSM states
//   - INES_MAGIC   : "NES\x1A", byte 0 in the low byte
//   - bank sizes and trainer length in bytes
//   - MF_*         : bit positions inside mapper_flags
//   - ines_magic_byte() : magic byte for header index 0..3
package ines_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERR
  } ines_state_e;

  localparam logic [31:0] INES_MAGIC = 32'h1A53454E;

  localparam int PRG_BANK_BYTES = 16384;
  localparam int CHR_BANK_BYTES = 8192;
  localparam int TRAINER_BYTES  = 512;

  localparam int MF_MAPPER_LSB    = 0;   // [11:0]
  localparam int MF_SUBMAPPER_LSB = 12;  // [15:12]
  localparam int MF_VERT          = 16;
  localparam int MF_FOUR          = 17;
  localparam int MF_BATT          = 18;
  localparam int MF_CHR_RAM       = 19;
  localparam int MF_NES2          = 20;

  // 16 header bytes, hdr[i] is header byte i
  typedef logic [15:0][7:0] ines_hdr_t;

  function automatic logic [7:0] ines_magic_byte(input logic [1:0] idx);
    return 8'(INES_MAGIC >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/ines_header_decode.sv
// ines_header_decode: combinational decode of a 16-byte iNES header.
// Ports:
//   hdr          in  16x8  header bytes 0..15
//   mapper_flags out 32    mapper/submapper/mirroring/battery/CHR-RAM/NES2
//   prg_banks    out 12    16 KiB PRG bank count
//   chr_banks    out 12    8 KiB CHR bank count (0 = CHR-RAM)
//   trainer      out 1     512-byte trainer present
//   header_error out 1     no PRG, or unsupported NES 2.0 size form
// Build option: INES_NES2_EN enables NES 2.0 extended fields; otherwise
// every header is treated as iNES 1.0.
module ines_header_decode
  import ines_pkg::*;
(
  input  ines_hdr_t   hdr,
  output logic [31:0] mapper_flags,
  output logic [11:0] prg_banks,
  output logic [11:0] chr_banks,
  output logic        trainer,
  output logic        header_error
);

  logic       nes2;
  logic [3:0] mapper_hi, submapper, prg_hi, chr_hi;
  logic       size_form_err;

`ifdef INES_NES2_EN
  assign nes2          = (hdr[7][3:2] == 2'b10);
  assign mapper_hi     = nes2 ? hdr[8][3:0] : 4'h0;
  assign submapper     = nes2 ? hdr[8][7:4] : 4'h0;
  assign prg_hi        = nes2 ? hdr[9][3:0] : 4'h0;
  assign chr_hi        = nes2 ? hdr[9][7:4] : 4'h0;
  // MSB nibble 0xF selects the exponent-multiplier size form: not supported
  assign size_form_err = nes2 && (hdr[9][3:0] == 4'hF || hdr[9][7:4] == 4'hF);
`else
  assign nes2          = 1'b0;
  assign mapper_hi     = 4'h0;
  assign submapper     = 4'h0;
  assign prg_hi        = 4'h0;
  assign chr_hi        = 4'h0;
  assign size_form_err = 1'b0;
`endif

  assign prg_banks    = {prg_hi, hdr[4]};
  assign chr_banks    = {chr_hi, hdr[5]};
  assign trainer      = hdr[6][2];
  assign header_error = (prg_banks == 12'd0) || size_form_err;

  always_comb begin
    mapper_flags = '0;
    mapper_flags[MF_MAPPER_LSB +: 12]   = {mapper_hi, hdr[7][7:4], hdr[6][7:4]};
    mapper_flags[MF_SUBMAPPER_LSB +: 4] = submapper;
    mapper_flags[MF_VERT]               = hdr[6][0];
    mapper_flags[MF_FOUR]               = hdr[6][3];
    mapper_flags[MF_BATT]               = hdr[6][1];
    mapper_flags[MF_CHR_RAM]            = (chr_banks == 12'd0);
    mapper_flags[MF_NES2]               = nes2;
  end

  // magic bytes are checked by the stream logic; padding bytes carry nothing
  logic unused_hdr;
  assign unused_hdr = ^{hdr[3:0], hdr[15:8], hdr[7][3:0]};

endmodule

// File: rtl/ines_loader.sv
// ines_loader: streams an iNES 1.0 / NES 2.0 image into cartridge memory.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   indata, indata_clk  input byte stream with one-cycle strobe
//   mem_addr/data/write write port, one cycle after the accepted byte
//   mapper_flags, prg_banks, chr_banks  decoded header, held after byte 15
//   done, error         sticky load status
// Build option: INES_NES2_EN (see ines_header_decode).
module ines_loader
  import ines_pkg::*;
#(
  parameter int                ADDR_W   = 22,
  parameter logic [ADDR_W-1:0] PRG_BASE = 'h000000,
  parameter logic [ADDR_W-1:0] CHR_BASE = 'h200000,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        indata,
  input  logic              indata_clk,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_write,
  output logic [31:0]       mapper_flags,
  output logic [11:0]       prg_banks,
  output logic [11:0]       chr_banks,
  output logic              done,
  output logic              error
);

  // wide enough for base + 26-bit span without overflow
  localparam int CALC_W = ((ADDR_W > 26) ? ADDR_W : 26) + 2;

  ines_state_e state_q, state_d;
  logic [25:0] off_q;
  ines_hdr_t   hdr_q, hdr_cur;

  logic [31:0] dec_flags;
  logic [11:0] dec_prg, dec_chr;
  logic        dec_trainer, dec_err;
  logic        prg_ovr, chr_ovr;
  logic [25:0] prg_len, chr_len;
  logic        loading;

  // decode sees the byte being accepted, so byte 15 is checked on its strobe
  always_comb begin
    hdr_cur = hdr_q;
    hdr_cur[off_q[3:0]] = indata;
  end

  ines_header_decode u_dec (
    .hdr          (hdr_cur),
    .mapper_flags (dec_flags),
    .prg_banks    (dec_prg),
    .chr_banks    (dec_chr),
    .trainer      (dec_trainer),
    .header_error (dec_err)
  );

  // PRG must end at or before CHR_BASE; CHR must end at or before MAX_ADDR
  assign prg_ovr = (CALC_W'(PRG_BASE) + CALC_W'(dec_prg) * CALC_W'(PRG_BANK_BYTES))
                   > CALC_W'(CHR_BASE);
  assign chr_ovr = (CALC_W'(CHR_BASE) + CALC_W'(dec_chr) * CALC_W'(CHR_BANK_BYTES))
                   > (CALC_W'(MAX_ADDR) + CALC_W'(1));

  assign prg_len = 26'(prg_banks) * 26'(PRG_BANK_BYTES);
  assign chr_len = 26'(chr_banks) * 26'(CHR_BANK_BYTES);
  assign loading = (state_q != ST_DONE) && (state_q != ST_ERR);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (indata_clk) begin
      case (state_q)
        ST_HDR: begin
          if (off_q[3:0] < 4'd4 && indata != ines_magic_byte(off_q[1:0]))
            state_d = ST_ERR;
          else if (off_q[3:0] == 4'd15) begin
            if (dec_err || prg_ovr || chr_ovr) state_d = ST_ERR;
            else if (dec_trainer)              state_d = ST_TRAINER;
            else                               state_d = ST_PRG;
          end
        end
        ST_TRAINER: if (off_q == 26'(TRAINER_BYTES - 1)) state_d = ST_PRG;
        ST_PRG:     if (off_q + 26'd1 == prg_len)
                      state_d = (chr_banks == 12'd0) ? ST_DONE : ST_CHR;
        ST_CHR:     if (off_q + 26'd1 == chr_len) state_d = ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_q        <= '0;
      hdr_q        <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write    <= 1'b0;
      mapper_flags <= '0;
      prg_banks    <= '0;
      chr_banks    <= '0;
    end else begin
      mem_write <= 1'b0;
      if (indata_clk && loading) begin
        // offset restarts at every region boundary
        off_q <= (state_d != state_q) ? '0 : off_q + 26'd1;
        if (state_q == ST_HDR) begin
          hdr_q[off_q[3:0]] <= indata;
          if (off_q[3:0] == 4'd15) begin
            mapper_flags <= dec_flags;
            prg_banks    <= dec_prg;
            chr_banks    <= dec_chr;
          end
        end
        if (state_q == ST_PRG || state_q == ST_CHR) begin
          mem_write <= 1'b1;
          mem_data  <= indata;
          mem_addr  <= ((state_q == ST_PRG) ? PRG_BASE : CHR_BASE) + ADDR_W'(off_q);
        end
      end
    end
  end

  assign done  = (state_q == ST_DONE);
  assign error = (state_q == ST_ERR);

endmodule

// File: tb/tb_ines_loader.sv
module tb_ines_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  indata = '0;
  logic        indata_clk = 1'b0;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic [31:0] mapper_flags;
  logic [11:0] prg_banks, chr_banks;
  logic        done, error;

  always #5 clk = ~clk;

  ines_loader dut (
    .clk          (clk),
    .reset        (reset),
    .indata       (indata),
    .indata_clk   (indata_clk),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_write    (mem_write),
    .mapper_flags (mapper_flags),
    .prg_banks    (prg_banks),
    .chr_banks    (chr_banks),
    .done         (done),
    .error        (error)
  );

  typedef struct packed {
    logic [21:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // every write must match the oldest expected write; done/error exclusive
  always @(negedge clk) begin
    chk("done_err_excl", 64'(done & error), 64'd0);
    if (mem_write) begin
      if (exp_q.size() == 0) chk("spurious_wr", 64'(mem_write), 64'd0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.a));
        chk("wr_data", 64'(mem_data), 64'(e.d));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    indata     = b;
    indata_clk = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      indata_clk = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    indata_clk = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_hdr(input logic [7:0] b4, b5, b6, b7, b8, b9);
    send(8'h4E); send(8'h45); send(8'h53); send(8'h1A);
    send(b4); send(b5); send(b6); send(b7); send(b8); send(b9);
    repeat (6) send(8'h00);
  endtask

  function automatic logic [7:0] data_of(input int k, input int seed);
    return 8'(k * 7 + 3 + seed * 64);
  endfunction

  task automatic send_data(input logic [21:0] base, input int k0, input int k1, input int seed);
    for (int k = k0; k < k1; k++) begin
      exp_q.push_back('{a: base + 22'(k), d: data_of(k, seed)});
      send(data_of(k, seed));
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_a"}, {mem_addr, mem_data, mem_write, done, error}, 64'd0);
    chk({tag, "_b"}, {mapper_flags, prg_banks, chr_banks}, 64'd0);
  endtask

  initial begin
    // reset state
    idle(2);
    chk_idle_outs("rst");
    reset = 1'b0;

    // mapper 0, 1 PRG, 1 CHR, vertical mirroring
    send_hdr(8'd1, 8'd1, 8'h01, 8'h00, 8'h00, 8'h00);
    idle(1);
    chk("t1_flags", 64'(mapper_flags), 64'h0001_0000);
    chk("t1_prg", 64'(prg_banks), 64'd1);
    chk("t1_chr", 64'(chr_banks), 64'd1);
    send_data(22'h000000, 0, 16384, 0);
    send_data(22'h200000, 0, 8191, 1);
    chk("t1_done_early", 64'(done), 64'd0);
    send_data(22'h200000, 8191, 8192, 1);
    idle(1);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_err", 64'(error), 64'd0);
    idle(1);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // bad magic at byte 2
    do_reset();
    send(8'h4E); send(8'h45);
    idle(1);
    chk("t2_err_pre", 64'(error), 64'd0);
    send(8'h54);
    idle(1);
    chk("t2_err", 64'(error), 64'd1);
    send_hdr(8'd1, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (8) send(8'h55);
    idle(2);
    chk("t2_err_sticky", 64'(error), 64'd1);
    chk("t2_done", 64'(done), 64'd0);
    chk("t2_flags", 64'(mapper_flags), 64'd0);

    // trainer + mapper 4 + CHR-RAM
    do_reset();
    send_hdr(8'd1, 8'd0, 8'h44, 8'h00, 8'h00, 8'h00);
    repeat (512) send(8'hAA);
    idle(1);
    chk("t3_flags", 64'(mapper_flags), 64'h0008_0004);
    chk("t3_chr", 64'(chr_banks), 64'd0);
    send_data(22'h000000, 0, 16384, 2);
    idle(1);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_err", 64'(error), 64'd0);
    send_data(22'h000000, 0, 0, 2);
    repeat (4) send(8'h11);
    idle(2);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_done_sticky", 64'(done), 64'd1);

    // PRG span overruns CHR_BASE
    do_reset();
    send_hdr(8'd129, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(1);
    chk("t4_err", 64'(error), 64'd1);
    chk("t4_prg", 64'(prg_banks), 64'd129);

    // zero PRG banks
    do_reset();
    send_hdr(8'd0, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(1);
    chk("t5_err", 64'(error), 64'd1);

    // NES 2.0 header fields
    do_reset();
    send_hdr(8'h00, 8'h00, 8'h10, 8'h08, 8'h21, 8'h01);
    idle(1);
`ifdef INES_NES2_EN
    chk("t6_flags", 64'(mapper_flags), 64'h0018_2101);
    chk("t6_prg", 64'(prg_banks), 64'd256);
    chk("t6_err", 64'(error), 64'd1);  // 4 MiB PRG overruns CHR_BASE
`else
    chk("t6_flags", 64'(mapper_flags), 64'h0008_0001);
    chk("t6_prg", 64'(prg_banks), 64'd0);
    chk("t6_err", 64'(error), 64'd1);  // decodes as iNES 1.0 with 0 PRG
`endif

    // reset mid-PRG, then a fresh load
    do_reset();
    send_hdr(8'd1, 8'd1, 8'h10, 8'h00, 8'h00, 8'h00);
    send_data(22'h000000, 0, 100, 3);
    @(negedge clk);
    reset      = 1'b1;
    indata     = 8'h77;
    indata_clk = 1'b1;
    @(negedge clk);
    indata_clk = 1'b0;
    chk_idle_outs("t7_rst");
    chk("t7_q_empty", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    send_hdr(8'd1, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    send_data(22'h000000, 0, 16384, 4);
    idle(1);
    chk("t7_done", 64'(done), 64'd1);
    chk("t7_flags", 64'(mapper_flags), 64'h0008_0000);
    idle(1);
    chk("t7_q_empty2", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
